// File: rtl/refill_arbiter_pkg.sv
// Shared constants for the refill arbiter: FSM state encoding, fixed AXI
// AR field values, client IDs and the address alignment helper.
package refill_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_AR    = 2'd1;
  localparam logic [1:0] ST_R     = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [2:0] ARSIZE_WORD  = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;

  localparam logic [3:0] ID_ICACHE = 4'd0;
  localparam logic [3:0] ID_DCACHE = 4'd1;

  // Clear the low 'low_bits' bits of an address.
  function automatic logic [31:0] align_addr(input logic [31:0] addr, input int low_bits);
    logic [31:0] mask_s;
    mask_s = 32'hFFFF_FFFF << low_bits;
    return addr & mask_s;
  endfunction

endpackage

// File: rtl/refill_arbiter.sv
// Arbitrates icache and dcache refill requests onto a single AXI read
// channel: one outstanding transaction, round-robin on ties, beats steered
// to the owning client, and a fixed hold-off after each burst so the
// client's return buffer can release its request before re-arbitration.
module refill_arbiter
  import refill_arbiter_pkg::*;
#(
  parameter int OFFSET_WIDTH = 2,
  parameter int HOLDOFF      = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_single,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arid,
  output logic        arvalid,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  output logic        rready,
  output logic        i_rready,
  output logic        d_rready,
  output logic [31:0] i_rdata,
  output logic [31:0] d_rdata,
  output logic        i_rlast,
  output logic        d_rlast,
  output logic        err
);

  localparam int         CW        = OFFSET_WIDTH + 1;
  localparam int         HCW       = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [7:0] BURST_LEN = 8'((1 << OFFSET_WIDTH) - 1);

  logic [1:0]     state_r, state_s;
  logic           owner_r;        // 1 = dcache owns the current transaction
  logic           last_grant_r;   // 1 = dcache was granted last
  logic [31:0]    araddr_r;
  logic [7:0]     arlen_r;
  logic [3:0]     arid_r;
  logic [CW-1:0]  beat_cnt_r;
  logic [HCW-1:0] drain_cnt_r;
  logic           err_r;

  logic grant_s, grant_d_s, beat_s, at_len_s, err_set_s;

  // Arbitration and beat qualification decode.
  always_comb begin
    grant_s   = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == ST_IDLE && (i_req || d_req)) begin
      grant_s   = 1'b1;
      grant_d_s = d_req && (!i_req || !last_grant_r);
    end else begin
      grant_s   = 1'b0;
      grant_d_s = 1'b0;
    end
    beat_s    = (state_r == ST_R) && rvalid;
    at_len_s  = (8'(beat_cnt_r) == arlen_r);
    err_set_s = (rvalid && (state_r != ST_R)) ||
                (beat_s && rlast && !at_len_s) ||
                (beat_s && !rlast && at_len_s);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_req || d_req) state_s = ST_AR;
        else                state_s = ST_IDLE;
      end
      ST_AR: begin
        if (arready) state_s = ST_R;
        else         state_s = ST_AR;
      end
      ST_R: begin
        if (rvalid && rlast) state_s = (HOLDOFF == 0) ? ST_IDLE : ST_DRAIN;
        else                 state_s = ST_R;
      end
      ST_DRAIN: begin
        if (drain_cnt_r == {HCW{1'b0}}) state_s = ST_IDLE;
        else                            state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Latch owner and AR fields at grant; they stay stable through AR and R.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_r      <= 1'b0;
      last_grant_r <= 1'b0;
      araddr_r     <= 32'd0;
      arlen_r      <= 8'd0;
      arid_r       <= 4'd0;
    end else if (grant_s) begin
      owner_r      <= grant_d_s;
      last_grant_r <= grant_d_s;
      if (grant_d_s) begin
        arid_r   <= ID_DCACHE;
        araddr_r <= d_single ? align_addr(d_addr, 2) : align_addr(d_addr, OFFSET_WIDTH + 2);
        arlen_r  <= d_single ? 8'd0 : BURST_LEN;
      end else begin
        arid_r   <= ID_ICACHE;
        araddr_r <= align_addr(i_addr, OFFSET_WIDTH + 2);
        arlen_r  <= BURST_LEN;
      end
    end else begin
      owner_r <= owner_r;
    end
  end

  // Beat counter: cleared on AR handshake, counts accepted beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                 beat_cnt_r <= {CW{1'b0}};
    else if (state_r == ST_AR && arready)      beat_cnt_r <= {CW{1'b0}};
    else if (beat_s)                           beat_cnt_r <= beat_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    else                                       beat_cnt_r <= beat_cnt_r;
  end

  // Hold-off down-counter: loaded on the last beat, counts DRAIN cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                         drain_cnt_r <= {HCW{1'b0}};
    else if (beat_s && rlast)                          drain_cnt_r <= HCW'(HOLDOFF - 1);
    else if (state_r == ST_DRAIN && drain_cnt_r != {HCW{1'b0}})
                                                       drain_cnt_r <= drain_cnt_r - {{(HCW-1){1'b0}}, 1'b1};
    else                                               drain_cnt_r <= drain_cnt_r;
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          err_r <= 1'b0;
    else if (err_set_s) err_r <= 1'b1;
    else                err_r <= err_r;
  end

  assign araddr   = araddr_r;
  assign arlen    = arlen_r;
  assign arid     = arid_r;
  assign arsize   = ARSIZE_WORD;
  assign arburst  = ARBURST_INCR;
  assign arvalid  = (state_r == ST_AR);
  assign rready   = (state_r == ST_R);
  assign i_rready = beat_s && !owner_r;
  assign d_rready = beat_s && owner_r;
  assign i_rdata  = rdata;
  assign d_rdata  = rdata;
  assign i_rlast  = i_rready && rlast;
  assign d_rlast  = d_rready && rlast;
  assign err      = err_r;

endmodule
